// File: rtl/freq_switch_ctrl_if.sv
// Rate-change request bus shared by the two requesters of freq_switch_ctrl.
// The master side drives the requests; the controller is the slave.
interface freq_switch_ctrl_if;
  logic [1:0] req_valid;
  logic [7:0] req_rate0;
  logic [7:0] req_rate1;
  logic [1:0] req_ready;
  logic       req_err;

  modport master (
    output req_valid, req_rate0, req_rate1,
    input  req_ready, req_err
  );

  modport slave (
    input  req_valid, req_rate0, req_rate1,
    output req_ready, req_err
  );
endinterface

// File: rtl/freq_switch_ctrl.sv
// Glitch-free runtime controller for an integer clock divider with two arbitrated requesters.
// Optional macro FSC_RR_ARB_EN selects round-robin arbitration (fixed priority to requester 0 otherwise).
module freq_switch_ctrl #(
  parameter logic [7:0] DEFAULT_RATE = 8'd4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_run,
  freq_switch_ctrl_if.slave         req,
  output logic                      o_clk_out,
  output logic                      o_tick,
  output logic [7:0]                o_cur_rate,
  output logic                      o_busy
);

  typedef enum logic {ST_STOP = 1'b0, ST_RUN = 1'b1} state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_rate, w_rate_nxt;
  logic [7:0] r_pend, w_pend_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_clk_out, r_tick;
  logic [1:0] w_gnt;
  logic [7:0] w_acc_rate;
  logic       w_acc, w_acc_legal;
`ifdef FSC_RR_ARB_EN
  logic       r_prio1;
`endif

  // Arbiter: grants only while no legal change is pending, one grant per cycle.
  always_comb begin
    w_gnt = 2'b00;
    if (i_rst || r_busy) begin
      w_gnt = 2'b00;
    end else begin
      case (req.req_valid)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
`ifdef FSC_RR_ARB_EN
        2'b11:   w_gnt = r_prio1 ? 2'b10 : 2'b01;
`else
        2'b11:   w_gnt = 2'b01;
`endif
        default: w_gnt = 2'b00;
      endcase
    end
  end

  assign w_acc_rate    = w_gnt[1] ? req.req_rate1 : req.req_rate0;
  assign w_acc         = |w_gnt;
  assign w_acc_legal   = w_acc && (w_acc_rate >= 8'd2);
  assign req.req_ready = w_gnt;
  assign req.req_err   = w_acc && !w_acc_legal;

  // Next-state logic for the STOP/RUN machine, counter, rate and pending change.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rate_nxt  = r_rate;
    w_pend_nxt  = r_pend;
    w_busy_nxt  = r_busy;
    case (r_state)
      ST_STOP: begin
        w_cnt_nxt = 8'd0;
        if (w_acc_legal) begin
          w_rate_nxt = w_acc_rate;
        end else begin
          w_rate_nxt = r_rate;
        end
        if (i_run) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_STOP;
        end
      end
      ST_RUN: begin
        // Grants only happen with busy low, so setting and clearing busy never collide.
        if (w_acc_legal) begin
          w_pend_nxt = w_acc_rate;
          w_busy_nxt = 1'b1;
        end else begin
          w_pend_nxt = r_pend;
        end
        if (r_cnt == (r_rate - 8'd1)) begin
          w_cnt_nxt = 8'd0;
          if (r_busy) begin
            w_rate_nxt = r_pend;
            w_busy_nxt = 1'b0;
          end else begin
            w_rate_nxt = r_rate;
          end
          if (i_run) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_STOP;
          end
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_STOP;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // State, counter and registered outputs; outputs are derived from next-state values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_STOP;
      r_cnt     <= 8'd0;
      r_rate    <= DEFAULT_RATE;
      r_pend    <= 8'd0;
      r_busy    <= 1'b0;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rate    <= w_rate_nxt;
      r_pend    <= w_pend_nxt;
      r_busy    <= w_busy_nxt;
      r_clk_out <= (w_state_nxt == ST_RUN) && (w_cnt_nxt < (w_rate_nxt >> 1));
      r_tick    <= (w_state_nxt == ST_RUN) && (w_cnt_nxt == 8'd0);
    end
  end

`ifdef FSC_RR_ARB_EN
  // Round-robin pointer: after any grant, favour the other requester.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prio1 <= 1'b0;
    end else if (w_acc) begin
      r_prio1 <= w_gnt[0];
    end else begin
      r_prio1 <= r_prio1;
    end
  end
`endif

  assign o_clk_out  = r_clk_out;
  assign o_tick     = r_tick;
  assign o_cur_rate = r_rate;
  assign o_busy     = r_busy;

endmodule

// File: doc/freq_switch_ctrl.md
# freq_switch_ctrl

Runtime controller for an integer clock divider. Two requesters share the divider through an arbiter, and each can submit a new divide ratio. A ratio change is applied only on an output-period boundary, so `clk_out` never produces a runt pulse. A `run` input starts and stops the divided output cleanly, and `tick` marks each period start for downstream enable logic.

## Interface
- `DEFAULT_RATE`, default 8'd4: divide ratio loaded at reset. Legal range is 2–255.
- `clk`  in  1  single system clock. All logic is posedge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  level: 1 = produce divided output, 0 = stop at the end of the current period.
- `req_valid`  in  2  per-requester rate-change request. Held high until accepted.
- `req_rate0`  in  8  ratio requested by requester 0.
- `req_rate1`  in  8  ratio requested by requester 1.
- `req_ready`  out  2  one-hot accept. A transfer occurs in a cycle where `req_valid[i] & req_ready[i]`. May depend combinationally on `req_valid`.
- `req_err`  out  1  high in the accept cycle if the accepted ratio is illegal (<2).
- `clk_out`  out  1  registered divided clock.
- `tick`  out  1  registered one-cycle pulse on each `clk_out` rising edge.
- `cur_rate`  out  8  ratio currently in effect.
- `busy`  out  1  a legal change is pending and not yet applied.

## Operation
- **Reset values:** STOP state; `cnt`=0; `clk_out`=0; `tick`=0; `cur_rate`=`DEFAULT_RATE`; `busy`=0; pending register cleared; arbitration pointer favours requester 0; `req_ready`=0; `req_err`=0.
- **State machine:** STOP and RUN. A pending change is tracked by the `busy` flag, not by a separate state.
- **STOP:**
  - `clk_out`=0, `cnt`=0.
  - `run`=1 sampled → go to RUN, starting a period at `cnt`=0.
- **RUN:**
  - `cnt` counts 0..R−1 and wraps, where R=`cur_rate`.
  - `clk_out`=1 while `cnt` < R/2 (integer divide), else 0. This gives R/2 cycles high and R−R/2 cycles low.
  - `tick`=1 when `cnt`=0.
- **Period boundary:** the cycle with `cnt`=R−1. At the following edge:
  - If `busy`: load the pending ratio into `cur_rate` and clear `busy`.
  - If `run`=0: go to STOP.
  - Otherwise: restart at `cnt`=0 using the (possibly new) `cur_rate`.
- **Stop request:** `run` deasserting mid-period does not truncate the period. If `run` reasserts before the boundary, the output continues uninterrupted.
- **Arbitration:**
  - Grants are issued only while `busy`=0. At most one grant per cycle.
  - One valid requester → it is granted.
  - Both valid → the requester not granted last wins, and the pointer updates on every grant.
- **Accept, illegal ratio (0 or 1):** `req_ready` and `req_err` pulse together; no state change.
- **Accept, legal ratio, in STOP:** `cur_rate` updates at the next edge; `busy` never asserts.
- **Accept, legal ratio, in RUN:** ratio is stored; `busy`=1 from the next cycle until the boundary load.
- **Accept on the boundary cycle itself:** the new ratio is stored and applies at the *next* boundary, not the current one.

## Timing
- `run` sampled 1 at edge E in STOP → `clk_out`=1 and `tick`=1 in the cycle after E.
- `clk_out` period = R cycles. `tick` spacing = R cycles.
- Request to apply, in RUN: at most R cycles after the accept cycle, where R is the ratio in effect when the request was accepted.
- `busy` falls in the same cycle `cur_rate` changes and the new period's `tick` fires.
- Mid-operation `rst`: takes effect at the next edge and discards any pending ratio.
- No combinational path from `req_valid` to `clk_out`, `tick` or `cur_rate`.

## Configuration
- **`FSC_RR_ARB_EN` defined:** round-robin arbitration between the two requesters, as described in Operation.
- **`FSC_RR_ARB_EN` undefined:** fixed priority; requester 0 always wins a simultaneous request, and the pointer logic is removed. All other behaviour is identical.

## Test plan
1. **Default start-up:** reset with `DEFAULT_RATE`=4, then `run`=1.
   - `clk_out` = 1,1,0,0 repeating, starting one cycle after `run` is sampled.
   - `tick` every 4 cycles; `cur_rate`=4.
2. **Odd and extreme ratios:** in STOP, req0 requests rate 3 and is accepted; then `run`=1.
   - `clk_out` = 1,0,0 repeating; `busy` stays 0.
   - Repeat with rate 255: 127 cycles high, 128 cycles low.
3. **Mid-period change:** running at rate 8, req1 requests rate 5 while `cnt`=2.
   - `req_ready[1]` pulses that cycle; `busy`=1.
   - The current period completes its 8 cycles; the next period is 5 cycles (2 high, 3 low).
   - `busy`→0 and `cur_rate`=5 coincide with that period's `tick`.
4. **Simultaneous requests:** `req_valid`=2'b11 with rates 6 and 10, held.
   - With `FSC_RR_ARB_EN`: req0 is granted first; req1 is granted only after `busy` clears; final `cur_rate`=10.
   - Without the macro: req0 wins every contention.
5. **Illegal ratio:** req0 requests rate 1 while running at rate 4.
   - `req_ready[0]`=1 and `req_err`=1 for one cycle.
   - `cur_rate` stays 4; `busy` stays 0; waveform is unchanged.
6. **Stop and reset behaviour:**
   - `run`→0 at `cnt`=1 of a rate-6 period → the period completes, then `clk_out`=0 and `tick` stops.
   - `rst` asserted while `busy`=1 → next cycle `cur_rate`=`DEFAULT_RATE`, `busy`=0, `clk_out`=0.
